// File: rtl/keypad_scanner_mx.sv
// -----------------------------------------------------------------------------
// keypad_scanner_mx
//
// Matrix-keypad scanner. Walks an active-low strobe across the rows, samples
// the synchronised active-low columns once per row, and classifies each scan
// frame as NONE, SINGLE(code) or MULTI. A frame result is only acted on after
// DEBOUNCE_FRAMES identical frames in a row. Committed changes become
// press/release events in a small valid/ready FIFO.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   row         row drive, active-low, one row low at a time while scanning
//   column      column sense, active-low (pulled up), asynchronous to clk
//   ev_valid    FIFO head holds an event
//   ev_ready    consumer takes the head event when ev_valid & ev_ready
//   ev_code     head event key code = r*NUM_COLS + c
//   ev_release  head event is a release (0 = press)
//   key_down    a debounced single key is currently held
//   key_held    code of the held key (keeps its last value when released)
//   ghost       one-cycle pulse when a multi-key frame result is committed
//   overflow    one-cycle pulse when an event is dropped on a full FIFO
// -----------------------------------------------------------------------------
module keypad_scanner_mx #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int FRAME_CYCLES    = 500000,
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPORT_RELEASE  = 1,
    localparam int CODE_W         = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_ROWS-1:0] row,
    input  logic [NUM_COLS-1:0] column,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [CODE_W-1:0]   ev_code,
    output logic                ev_release,
    output logic                key_down,
    output logic [CODE_W-1:0]   key_held,
    output logic                ghost,
    output logic                overflow
);

    localparam int NK      = NUM_ROWS * NUM_COLS;
    localparam int CNT_MAX = (FRAME_CYCLES > SETTLE_CYCLES) ? FRAME_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RIDX_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FILL_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_NONE   = 2'd0,
        K_SINGLE = 2'd1,
        K_MULTI  = 2'd2
    } kind_t;

    // Classify a frame by how many contacts it saw.
    function automatic kind_t frame_kind(input logic [NK-1:0] a);
        kind_t k;
        k = K_NONE;
        for (int i = 0; i < NK; i++) begin
            if (a[i]) begin
                k = (k == K_NONE) ? K_SINGLE : K_MULTI;
            end else begin
                k = k;
            end
        end
        return k;
    endfunction

    // Index of the active bit; only meaningful when exactly one bit is set.
    function automatic logic [CODE_W-1:0] frame_code(input logic [NK-1:0] a);
        logic [CODE_W-1:0] c;
        c = {CODE_W{1'b0}};
        for (int i = 0; i < NK; i++) begin
            if (a[i]) begin
                c = CODE_W'(i);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // Registers and their next-state values
    logic [NUM_COLS-1:0] col_s1_q, col_s2_q;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RIDX_W-1:0]   ridx_q, ridx_d;
    logic [NUM_ROWS-1:0] row_q, row_d;
    logic [NK-1:0]       acc_q, acc_d;
    kind_t               cand_kind_q, cand_kind_d;
    logic [CODE_W-1:0]   cand_code_q, cand_code_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    kind_t               com_kind_q, com_kind_d;
    logic [CODE_W-1:0]   com_code_q, com_code_d;
    logic                key_down_q, key_down_d;
    logic [CODE_W-1:0]   key_held_q, key_held_d;
    logic                ghost_q, ghost_d;
    logic                overflow_q, overflow_d;
    logic [CODE_W-1:0]   fifo_code_q [FIFO_DEPTH];
    logic [CODE_W-1:0]   fifo_code_d [FIFO_DEPTH];
    logic                fifo_rel_q  [FIFO_DEPTH];
    logic                fifo_rel_d  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;

    // Combinational helpers
    kind_t               res_kind_s;
    logic [CODE_W-1:0]   res_code_s;
    logic                push_s;
    logic [CODE_W-1:0]   push_code_s;
    logic                push_rel_s;
    logic                pop_s;
    logic                full_s;
    logic                push_ok_s;

    // Frame sequencer: idle gap, per-row settle/sample, one evaluation cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ridx_d  = ridx_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
                    state_d = ST_SCAN;
                    cnt_d   = {CNT_W{1'b0}};
                    ridx_d  = {RIDX_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    // Last settle cycle: the synchronised column now reflects this row.
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        acc_d[r*NUM_COLS +: NUM_COLS] = (ridx_q == RIDX_W'(r)) ?
                            ~col_s2_q : acc_q[r*NUM_COLS +: NUM_COLS];
                    end
                    cnt_d = {CNT_W{1'b0}};
                    if (ridx_q == RIDX_W'(NUM_ROWS - 1)) begin
                        state_d = ST_EVAL;
                    end else begin
                        ridx_d = ridx_q + RIDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EVAL: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                ridx_d  = {RIDX_W{1'b0}};
            end
        endcase
    end

    // Row drive is computed from the next state so the registered row tracks state_q.
    always_comb begin
        row_d = {NUM_ROWS{1'b1}};
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_d[r] = !((state_d == ST_SCAN) && (ridx_d == RIDX_W'(r)));
        end
    end

    // Frame classification, debounce and commit actions (active only in EVAL).
    always_comb begin
        res_kind_s  = frame_kind(acc_q);
        // Code is forced to zero for NONE/MULTI so that plain equality compares results.
        res_code_s  = (res_kind_s == K_SINGLE) ? frame_code(acc_q) : {CODE_W{1'b0}};
        cand_kind_d = cand_kind_q;
        cand_code_d = cand_code_q;
        deb_cnt_d   = deb_cnt_q;
        com_kind_d  = com_kind_q;
        com_code_d  = com_code_q;
        key_down_d  = key_down_q;
        key_held_d  = key_held_q;
        ghost_d     = 1'b0;
        push_s      = 1'b0;
        push_code_s = {CODE_W{1'b0}};
        push_rel_s  = 1'b0;
        if (state_q == ST_EVAL) begin
            if ((res_kind_s == cand_kind_q) && (res_code_s == cand_code_q)) begin
                if (deb_cnt_q < DEB_W'(DEBOUNCE_FRAMES)) begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end else begin
                    deb_cnt_d = deb_cnt_q;
                end
            end else begin
                cand_kind_d = res_kind_s;
                cand_code_d = res_code_s;
                deb_cnt_d   = DEB_W'(1);
            end
            if ((deb_cnt_d == DEB_W'(DEBOUNCE_FRAMES)) &&
                ((cand_kind_d != com_kind_q) || (cand_code_d != com_code_q))) begin
                com_kind_d = cand_kind_d;
                com_code_d = cand_code_d;
                case (cand_kind_d)
                    K_SINGLE: begin
                        push_s      = 1'b1;
                        push_code_s = cand_code_d;
                        push_rel_s  = 1'b0;
                        key_down_d  = 1'b1;
                        key_held_d  = cand_code_d;
                    end
                    K_NONE: begin
                        key_down_d = 1'b0;
                        // Leaving MULTI has no single key to report a release for.
                        if ((com_kind_q == K_SINGLE) && (REPORT_RELEASE != 0)) begin
                            push_s      = 1'b1;
                            push_code_s = com_code_q;
                            push_rel_s  = 1'b1;
                        end else begin
                            push_s = 1'b0;
                        end
                    end
                    K_MULTI: begin
                        ghost_d = 1'b1;
                    end
                    default: begin
                        ghost_d = 1'b0;
                    end
                endcase
            end else begin
                com_kind_d = com_kind_q;
            end
        end else begin
            deb_cnt_d = deb_cnt_q;
        end
    end

    // Event FIFO: a push on a full FIFO survives only if the head pops in the same cycle.
    always_comb begin
        pop_s       = (fill_q != {FILL_W{1'b0}}) && ev_ready;
        full_s      = (fill_q == FILL_W'(FIFO_DEPTH));
        push_ok_s   = push_s && (!full_s || pop_s);
        overflow_d  = push_s && full_s && !pop_s;
        fifo_code_d = fifo_code_q;
        fifo_rel_d  = fifo_rel_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_ok_s) begin
            fifo_code_d[wr_ptr_q] = push_code_s;
            fifo_rel_d[wr_ptr_q]  = push_rel_s;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // State registers, including the two-flop column synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q    <= {NUM_COLS{1'b1}};
            col_s2_q    <= {NUM_COLS{1'b1}};
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            ridx_q      <= {RIDX_W{1'b0}};
            row_q       <= {NUM_ROWS{1'b1}};
            acc_q       <= {NK{1'b0}};
            cand_kind_q <= K_NONE;
            cand_code_q <= {CODE_W{1'b0}};
            deb_cnt_q   <= {DEB_W{1'b0}};
            com_kind_q  <= K_NONE;
            com_code_q  <= {CODE_W{1'b0}};
            key_down_q  <= 1'b0;
            key_held_q  <= {CODE_W{1'b0}};
            ghost_q     <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_code_q[i] <= {CODE_W{1'b0}};
                fifo_rel_q[i]  <= 1'b0;
            end
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            fill_q      <= {FILL_W{1'b0}};
        end else begin
            col_s1_q    <= column;
            col_s2_q    <= col_s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ridx_q      <= ridx_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            cand_kind_q <= cand_kind_d;
            cand_code_q <= cand_code_d;
            deb_cnt_q   <= deb_cnt_d;
            com_kind_q  <= com_kind_d;
            com_code_q  <= com_code_d;
            key_down_q  <= key_down_d;
            key_held_q  <= key_held_d;
            ghost_q     <= ghost_d;
            overflow_q  <= overflow_d;
            fifo_code_q <= fifo_code_d;
            fifo_rel_q  <= fifo_rel_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
        end
    end

    assign row        = row_q;
    assign ev_valid   = (fill_q != {FILL_W{1'b0}});
    assign ev_code    = fifo_code_q[rd_ptr_q];
    assign ev_release = fifo_rel_q[rd_ptr_q];
    assign key_down   = key_down_q;
    assign key_held   = key_held_q;
    assign ghost      = ghost_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_scanner_mx.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner_mx
//
// Directed bench for keypad_scanner_mx. An ideal keypad matrix turns the bench
// key array into column levels. A frame-level model (timing from arithmetic on
// the cycle count, debounce as "last N frame results identical", FIFO as a
// queue) predicts every output on every cycle; literal expectations per
// scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_keypad_scanner_mx;

    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int FC    = 20;
    localparam int SC    = 4;
    localparam int DF    = 3;
    localparam int FD    = 2;
    localparam int FRAME = FC + NR * SC + 1;

    typedef struct {
        int code;
        bit rel;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] row;
    logic [NC-1:0] column;
    logic          ev_valid;
    logic          ev_ready;
    logic [3:0]    ev_code;
    logic          ev_release;
    logic          key_down;
    logic [3:0]    key_held;
    logic          ghost;
    logic          overflow;

    logic [NC-1:0] keys [NR];

    // Model state
    int     n;
    int     hist[$];
    int     committed;
    logic   kd;
    int     kh;
    logic   ghost_e;
    logic   ovf_e;
    ev_t    mq[$];
    // Observations
    ev_t    popped[$];
    int     ghost_cnt;
    int     ovf_cnt;
    bit     seen_valid;
    int     first_valid_n;
    // Counters
    int     n_vec;
    int     n_err;

    keypad_scanner_mx #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .FRAME_CYCLES(FC), .SETTLE_CYCLES(SC),
        .DEBOUNCE_FRAMES(DF), .FIFO_DEPTH(FD), .REPORT_RELEASE(1)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .column(column),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_release(ev_release), .key_down(key_down), .key_held(key_held),
        .ghost(ghost), .overflow(overflow)
    );

    initial forever #5 clk = ~clk;

    // Ideal diode-free matrix: a pressed key pulls its column low while its row is low.
    always_comb begin
        column = {NC{1'b1}};
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (!row[r] && keys[r][c]) column[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // -1 = no key, -2 = several keys, otherwise the key code.
    function automatic int frame_result();
        int cnt = 0;
        int code = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (keys[r][c]) begin
                    cnt++;
                    code = r * NC + c;
                end
        if (cnt == 0) return -1;
        if (cnt > 1) return -2;
        return code;
    endfunction

    function automatic bit hist_stable();
        if (hist.size() != DF) return 1'b0;
        for (int i = 1; i < DF; i++)
            if (hist[i] != hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    // Compare every cycle on the falling edge, then advance the model over the next rising edge.
    always @(negedge clk) begin : cmp
        int p;
        int sz;
        int res;
        bit pop;
        bit have_ev;
        ev_t ev;
        ev_t ob;
        logic [NR-1:0] exp_row;
        if (!rst) begin
            chk("rst_row", 32'(row), 32'hF);
            chk("rst_ev_valid", 32'(ev_valid), 32'd0);
            chk("rst_key_down", 32'(key_down), 32'd0);
            chk("rst_key_held", 32'(key_held), 32'd0);
            chk("rst_ghost", 32'(ghost), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            n = 0;
            hist.delete();
            mq.delete();
            committed = -1;
            kd = 1'b0;
            kh = 0;
            ghost_e = 1'b0;
            ovf_e = 1'b0;
        end else begin
            p = n % FRAME;
            exp_row = {NR{1'b1}};
            if (p >= FC && p < FC + NR * SC) exp_row[(p - FC) / SC] = 1'b0;
            chk("row", 32'(row), 32'(exp_row));
            chk("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("ev_code", 32'(ev_code), 32'(mq[0].code));
                chk("ev_release", 32'(ev_release), 32'(mq[0].rel));
            end
            chk("key_down", 32'(key_down), 32'(kd));
            chk("key_held", 32'(key_held), 32'(kh));
            chk("ghost", 32'(ghost), 32'(ghost_e));
            chk("overflow", 32'(overflow), 32'(ovf_e));
            if (ghost === 1'b1) ghost_cnt++;
            if (overflow === 1'b1) ovf_cnt++;
            if (ev_valid === 1'b1 && ev_ready) begin
                ob.code = int'(ev_code);
                ob.rel  = ev_release;
                popped.push_back(ob);
            end
            if (ev_valid === 1'b1 && !seen_valid) begin
                seen_valid = 1'b1;
                first_valid_n = n;
            end
            // Model transition across the next rising edge
            pop     = (mq.size() != 0) && ev_ready;
            sz      = mq.size();
            ghost_e = 1'b0;
            ovf_e   = 1'b0;
            have_ev = 1'b0;
            if (p == FRAME - 1) begin
                res = frame_result();
                hist.push_back(res);
                if (hist.size() > DF) void'(hist.pop_front());
                if (hist_stable() && res != committed) begin
                    if (res >= 0) begin
                        have_ev = 1'b1;
                        ev.code = res;
                        ev.rel  = 1'b0;
                        kd = 1'b1;
                        kh = res;
                    end else if (res == -1) begin
                        if (committed >= 0) begin
                            have_ev = 1'b1;
                            ev.code = committed;
                            ev.rel  = 1'b1;
                        end
                        kd = 1'b0;
                    end else begin
                        ghost_e = 1'b1;
                    end
                    committed = res;
                end
            end
            if (pop) void'(mq.pop_front());
            if (have_ev) begin
                if (sz < FD || pop) mq.push_back(ev);
                else ovf_e = 1'b1;
            end
            n++;
        end
    end

    // Advance to cycle 1 of the next frame (inside IDLE, safe to change keys).
    task automatic next_frame();
        @(posedge clk);
        #2;
        while (n % FRAME != 1) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < NR; r++) keys[r] = {NC{1'b0}};
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        n_vec = 0;
        n_err = 0;
        ghost_cnt = 0;
        ovf_cnt = 0;
        seen_valid = 1'b0;
        first_valid_n = 0;
        clear_keys();
        ev_ready = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Idle frames: row pattern checked every cycle by the model.
        repeat (10) next_frame();
        chk("s1_no_events", 32'(popped.size()), 32'd0);
        chk("s1_key_down", 32'(key_down), 32'd0);
        chk("s1_no_ghost", 32'(ghost_cnt), 32'd0);

        // Key (2,1) held 5 frames, then released.
        popped.delete();
        seen_valid = 1'b0;
        n0 = n;
        keys[2][1] = 1'b1;
        repeat (3) next_frame();
        chk("s2_key_down", 32'(key_down), 32'd1);
        chk("s2_key_held", 32'(key_held), 32'd9);
        chk("s2_latency", 32'(first_valid_n - n0), 32'd110);
        chk("s2_press_count", 32'(popped.size()), 32'd1);
        repeat (2) next_frame();
        clear_keys();
        repeat (3) next_frame();
        chk("s2_event_count", 32'(popped.size()), 32'd2);
        if (popped.size() == 2) begin
            chk("s2_press_code", 32'(popped[0].code), 32'd9);
            chk("s2_press_rel", 32'(popped[0].rel), 32'd0);
            chk("s2_rel_code", 32'(popped[1].code), 32'd9);
            chk("s2_rel_rel", 32'(popped[1].rel), 32'd1);
        end
        chk("s2_key_up", 32'(key_down), 32'd0);

        // Key (1,3): two frames, a bounce, then three stable frames.
        popped.delete();
        keys[1][3] = 1'b1;
        repeat (2) next_frame();
        chk("s3_no_early_event", 32'(popped.size()), 32'd0);
        clear_keys();
        next_frame();
        keys[1][3] = 1'b1;
        repeat (3) next_frame();
        chk("s3_one_press", 32'(popped.size()), 32'd1);
        if (popped.size() == 1) begin
            chk("s3_press_code", 32'(popped[0].code), 32'd7);
            chk("s3_press_rel", 32'(popped[0].rel), 32'd0);
        end
        clear_keys();
        repeat (3) next_frame();
        chk("s3_release_seen", 32'(popped.size()), 32'd2);

        // Ghost: (0,0) and (3,3) together for 4 frames.
        popped.delete();
        ghost_cnt = 0;
        keys[0][0] = 1'b1;
        keys[3][3] = 1'b1;
        repeat (4) next_frame();
        chk("s4_ghost_once", 32'(ghost_cnt), 32'd1);
        chk("s4_no_event", 32'(popped.size()), 32'd0);
        chk("s4_key_down", 32'(key_down), 32'd0);
        clear_keys();
        repeat (3) next_frame();
        chk("s4_no_event_after", 32'(popped.size()), 32'd0);
        chk("s4_ghost_total", 32'(ghost_cnt), 32'd1);

        // Overflow: consumer stalled while keys 0, 5, 10 are pressed and released.
        ev_ready = 1'b0;
        popped.delete();
        ovf_cnt = 0;
        foreach (keys[k]) keys[k] = {NC{1'b0}};
        for (int k = 0; k <= 10; k += 5) begin
            keys[k / NC][k % NC] = 1'b1;
            repeat (3) next_frame();
            clear_keys();
            repeat (3) next_frame();
        end
        chk("s5_overflows", 32'(ovf_cnt), 32'd4);
        chk("s5_key_held", 32'(key_held), 32'd10);
        chk("s5_head_valid", 32'(ev_valid), 32'd1);
        chk("s5_head_code", 32'(ev_code), 32'd0);
        chk("s5_head_rel", 32'(ev_release), 32'd0);
        ev_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("s5_drain_count", 32'(popped.size()), 32'd2);
        if (popped.size() == 2) begin
            chk("s5_drain0_code", 32'(popped[0].code), 32'd0);
            chk("s5_drain0_rel", 32'(popped[0].rel), 32'd0);
            chk("s5_drain1_code", 32'(popped[1].code), 32'd0);
            chk("s5_drain1_rel", 32'(popped[1].rel), 32'd1);
        end

        // Reset during SCAN with one queued event; key (1,2) stays pressed.
        ev_ready = 1'b0;
        keys[1][2] = 1'b1;
        repeat (3) next_frame();
        chk("s6_queued_valid", 32'(ev_valid), 32'd1);
        chk("s6_queued_code", 32'(ev_code), 32'd6);
        @(posedge clk);
        #2;
        while (n % FRAME != FC + 2) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        #1;
        chk("s6_rst_row", 32'(row), 32'hF);
        chk("s6_rst_valid", 32'(ev_valid), 32'd0);
        chk("s6_rst_code", 32'(ev_code), 32'd0);
        chk("s6_rst_release", 32'(ev_release), 32'd0);
        chk("s6_rst_key_down", 32'(key_down), 32'd0);
        chk("s6_rst_key_held", 32'(key_held), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        seen_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 200 && !seen_valid; i++) @(posedge clk);
        #2;
        chk("s6_event_after_reset", 32'(seen_valid), 32'd1);
        chk("s6_full_debounce", 32'(first_valid_n), 32'd111);
        chk("s6_code", 32'(ev_code), 32'd6);
        chk("s6_release", 32'(ev_release), 32'd0);
        ev_ready = 1'b1;
        clear_keys();
        repeat (4) next_frame();
        chk("s6_final_key_down", 32'(key_down), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
